rv32_instr_queue: RTL and testbench
===================================

// Module: rv32_instr_queue
// PURPOSE
//  Decoupling FIFO between the fetch instruction buffer and decode. It stores
//  {pc, instr} fetch packets (instr_buffer_data_t). It absorbs decode stalls so
//  fetch keeps issuing, and drops all queued packets on a control-flow flush.
//  Back-pressure reaches the fetch stage through in_ready.
// PARAMETERS
//  DEPTH   4   entries; power of two, >= 2
//  CNT_W   $clog2(DEPTH+1)   width of count (derived, localparam)
// PORTS
//  clk        in   1        clock, all state updates on posedge
//  resetn     in   1        asynchronous, active-low reset
//  flush      in   1        discard all entries (branch/jump/trap redirect)
//  in_valid   in   1        fetch packet present on in_data
//  in_data    in   instr_buffer_data_t  {pc, instr} from fetch
//  in_ready   out  1        queue can accept a packet this cycle
//  out_valid  out  1        out_data holds the oldest queued packet
//  out_data   out  instr_buffer_data_t  head packet to decode
//  out_ready  in   1        decode consumes head this cycle
//  count      out  CNT_W    number of valid entries, 0..DEPTH
// BEHAVIOUR
//  Reset (resetn=0, async): rd_ptr=wr_ptr=0, count=0, out_valid=0,
//   out_data.pc=0, out_data.instr=`RV_NOP, in_ready=1. Storage is not cleared.
//  push = in_valid & in_ready; pop = out_valid & out_ready.
//  in_ready = (count != DEPTH). There is no same-cycle pop-through when full,
//   so in_ready depends only on registered state.
//  out_valid = (count != 0). out_data = mem[rd_ptr] when valid, otherwise
//   {pc=0, instr=`RV_NOP}. Decode therefore sees a NOP bubble when empty.
//  Latency: a packet pushed at edge N is visible on out_* after edge N
//   (1 cycle). There is no combinational in->out bypass.
//  Order: strict FIFO. Each packet is delivered exactly once.
//  Pointers: log2(DEPTH) bits, increment modulo DEPTH (natural wrap).
//   count: +1 on push only, -1 on pop only, unchanged on push&pop.
//  Push and pop in the same cycle: legal at any non-full, non-empty level.
//   Empty: only the push happens. Full: only the pop happens (in_ready=0).
//  flush has priority over push and pop. On a flush edge: rd_ptr=wr_ptr=0,
//   count=0. A concurrent push is dropped and a concurrent pop is discarded.
//   out_valid=0 in the following cycle.
//  in_valid while in_ready=0: no state change. Upstream must hold the packet.
//  Packets with instr==`RV_NOP are queued like any other packet. Bubble
//   filtering is upstream's job, done via in_valid.
//  Reset mid-operation: immediate return to the reset state, with all
//   entries lost.
//  No illegal states are reachable. count never exceeds DEPTH or drops
//   below 0.
// TESTING (DEPTH=4)
//  1. Reset: out_valid=0, out_data.instr=`RV_NOP, count=0, in_ready=1.
//     Assert resetn low mid-clock -> outputs return to reset values at once.
//  2. Fill/drain: push pc 0x00,0x04,0x08,0x0C with out_ready=0
//     -> count=4, in_ready=0. A 5th push (pc 0x10) is held and not stored.
//     Then out_ready=1 -> pcs 0x00..0x0C pop in order, count falls to 0.
//  3. Latency: empty queue, push pc 0x40 at edge N -> out_valid=1 and
//     out_data.pc=0x40 after edge N, not before.
//  4. Simultaneous push+pop at count=2 for 10 cycles -> count stays 2,
//     order is preserved, and pointers wrap past index 3 without loss.
//  5. Flush with push+pop at count=3 -> next cycle count=0, out_valid=0.
//     The pushed packet never appears. Next push pc 0x80 is the first
//     packet out.
//  6. Random in_valid/out_ready/flush for 10k cycles -> scoreboard matches
//     and count equals the model every cycle.

Source files
------------

// File: rtl/rv32_instr_queue.sv
// rv32_instr_queue: fetch-to-decode FIFO of {pc, instr} packets with flush and back-pressure
`ifndef RV_NOP
`define RV_NOP 32'h0000_0013
`endif

package rv32_instr_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } instr_buffer_data_t;
  localparam logic [31:0] RV_NOP = `RV_NOP;
endpackage

module rv32_instr_queue
  import rv32_instr_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  input  instr_buffer_data_t in_data,
  output logic               in_ready,
  output logic               out_valid,
  output instr_buffer_data_t out_data,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  instr_buffer_data_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  assign in_ready  = count != CNT_W'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '{pc: 32'h0, instr: `RV_NOP};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  // storage is deliberately left uncleared by reset
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= in_data;
endmodule

// File: tb/tb_rv32_instr_queue.sv
// tb_rv32_instr_queue: scoreboard bench for rv32_instr_queue at DEPTH=4
module tb_rv32_instr_queue;
  import rv32_instr_queue_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, resetn = 0, flush = 0, in_valid = 0, out_ready = 0;
  instr_buffer_data_t in_data = '0, out_data;
  logic in_ready, out_valid;
  logic [2:0] count;
  logic [63:0] mq [$];
  int total = 0, bad = 0;

  rv32_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(mq.size()));
    chk({tag, "_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    chk({tag, "_ready"}, 64'(in_ready), 64'(mq.size() != DEPTH));
    chk({tag, "_data"}, out_data, mq.size() != 0 ? mq[0] : {32'h0, RV_NOP});
  endtask

  task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                     input logic orr, input logic fl, input string tag);
    logic mpush, mpop;
    in_valid = iv; in_data = '{pc: pc, instr: ins}; out_ready = orr; flush = fl;
    check_state(tag);
    mpush = iv && mq.size() != DEPTH;
    mpop = orr && mq.size() != 0;
    if (fl) mq.delete();
    else begin
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back({pc, ins});
    end
    @(posedge clk);
    #1;
    in_valid = 0; out_ready = 0; flush = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    resetn = 1;
    @(posedge clk);
    #1;
    // fill to full, attempt a fifth push, then drain in order
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 32'h1000 + 32'(i), 0, 0, "fill");
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    cyc(1, 32'h10, 32'hdead, 0, 0, "held");
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(out_data.pc), 64'(i * 4));
      cyc(0, 0, 0, 1, 0, "drain");
    end
    chk("drain_empty", 64'(count), 64'd0);
    // one-cycle latency
    cyc(1, 32'h40, RV_NOP, 0, 0, "lat_pre");
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_pc", 64'(out_data.pc), 64'h40);
    cyc(0, 0, 0, 1, 0, "lat_drain");
    // steady push+pop at count=2 wrapping the pointers
    cyc(1, 32'h100, 32'h11, 0, 0, "pp_fill");
    cyc(1, 32'h104, 32'h12, 0, 0, "pp_fill");
    for (int i = 0; i < 10; i++) cyc(1, 32'h108 + 32'(i * 4), 32'h20 + 32'(i), 1, 0, "pp");
    chk("pp_count", 64'(count), 64'd2);
    cyc(0, 0, 0, 1, 0, "pp_drain");
    cyc(0, 0, 0, 1, 0, "pp_drain");
    // flush beats concurrent push and pop
    for (int i = 0; i < 3; i++) cyc(1, 32'h200 + 32'(i * 4), 32'h33, 0, 0, "fl_fill");
    cyc(1, 32'hAA, 32'h44, 1, 1, "fl");
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    cyc(1, 32'h80, 32'h55, 0, 0, "fl_next");
    chk("fl_first_pc", 64'(out_data.pc), 64'h80);
    // asynchronous reset mid-cycle
    cyc(1, 32'h300, 32'h66, 0, 0, "ar_fill");
    #2 resetn = 0;
    #1;
    mq.delete();
    check_state("async_rst");
    #1 resetn = 1;
    @(posedge clk);
    #1;
    // random traffic
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0) ? RV_NOP : $urandom,
          1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, "rnd");
    check_state("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
